// File: rtl/npu_sigmoid_unit.sv
// -----------------------------------------------------------------------------
// npu_sigmoid_unit
//
// Activation stage at the tail of the NPU neuron chain. A 48-bit signed
// accumulator is rescaled to Q8.8 and saturated (stage 1). A piecewise-linear
// sigmoid is then applied (stage 2), and the 16-bit result is buffered in a
// first-word-fall-through FIFO behind a valid/ready handshake.
//
// A credit counter covers both pipeline stages plus the FIFO. An accepted word
// therefore always has a FIFO slot waiting for it, and stage 2 can write
// unconditionally.
//
// Optional feature (compile-time macro NPU_SIG_LINEAR_BYPASS_EN):
//   Adds input npu_sig_bypass. It travels with each accepted word. When set,
//   stage 2 emits the saturated Q8.8 value in place of the sigmoid.
//
// Parameters:
//   FIFO_DEPTH  output FIFO entries (power of 2, >= 2)
//   FRAC_BITS   fractional bits of PE data; the accumulator carries 2x this
//
// Ports:
//   CLK                 100 MHz clock
//   npu_rst_n           synchronous active-low reset
//   npu_sig_acc_valid   accumulator word presented
//   npu_sig_acc_in      signed 48-bit accumulator
//   npu_sig_acc_ready   unit can accept a word this cycle
//   npu_sig_out_valid   FIFO head valid
//   npu_sig_out_data    activation, unsigned Q8.8 (0x0000..0x0100)
//   npu_sig_out_ready   consumer takes the head this cycle
//   npu_sig_fifo_count  FIFO occupancy
//   npu_sig_overflow    sticky: word offered while not ready (word is dropped)
// -----------------------------------------------------------------------------
module npu_sigmoid_unit #(
  parameter int FIFO_DEPTH = 4,
  parameter int FRAC_BITS  = 8
) (
  input  logic                        CLK,
  input  logic                        npu_rst_n,
  input  logic                        npu_sig_acc_valid,
  input  logic signed [47:0]          npu_sig_acc_in,
`ifdef NPU_SIG_LINEAR_BYPASS_EN
  input  logic                        npu_sig_bypass,
`endif
  output logic                        npu_sig_acc_ready,
  output logic                        npu_sig_out_valid,
  output logic [15:0]                 npu_sig_out_data,
  input  logic                        npu_sig_out_ready,
  output logic [$clog2(FIFO_DEPTH):0] npu_sig_fifo_count,
  output logic                        npu_sig_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  // Symmetric saturation: -32768 is excluded so |v| always fits in 15 bits.
  localparam logic signed [47:0] SAT_MAX = 48'sd32767;
  localparam logic signed [47:0] SAT_MIN = -48'sd32767;

  // Control state
  logic [CNT_W-1:0] credits;
  logic [CNT_W-1:0] fifo_cnt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             s1_valid;
  logic             s2_valid;
  logic             overflow_q;

  // Datapath state
  logic signed [15:0] s1_v;
  logic [15:0]        s2_data;
  logic [15:0]        fifo_mem [FIFO_DEPTH];
`ifdef NPU_SIG_LINEAR_BYPASS_EN
  logic               s1_bypass;
`endif

  // Combinational nets
  logic               accept;
  logic               pop;
  logic signed [47:0] acc_shift;
  logic signed [15:0] sat_v;
  logic [15:0]        mag;
  logic [15:0]        sig_y;
  logic [15:0]        s2_next;

  // Ready depends only on the reset input and the credit register. There is
  // no path from out_ready, so the upstream timing path stays short.
  assign npu_sig_acc_ready  = npu_rst_n & (credits < DEPTH_C);
  assign npu_sig_out_valid  = (fifo_cnt != '0);
  assign npu_sig_fifo_count = fifo_cnt;
  assign npu_sig_overflow   = overflow_q;

  assign accept = npu_sig_acc_valid & npu_sig_acc_ready;
  assign pop    = npu_sig_out_valid & npu_sig_out_ready;

  // FIFO storage is not reset. Zero the data bus while the FIFO is empty so
  // that every output reads 0 out of reset.
  assign npu_sig_out_data = npu_sig_out_valid ? fifo_mem[rd_ptr] : 16'd0;

  // Stage 1: rescale to Q8.8 and saturate.
  // NOTE: every always_comb output gets a value on every path (here via a
  // full if/else chain). A missing branch would infer a latch.
  always_comb begin
    acc_shift = npu_sig_acc_in >>> FRAC_BITS;
    if (acc_shift > SAT_MAX) begin
      sat_v = 16'sd32767;
    end else if (acc_shift < SAT_MIN) begin
      sat_v = -16'sd32767;
    end else begin
      sat_v = acc_shift[15:0];
    end
  end

  // Stage 2: piecewise-linear sigmoid on |v|, then mirrored about 0.5
  // (256 - y) for negative inputs.
  always_comb begin
    mag = s1_v[15] ? 16'(-s1_v) : 16'(s1_v);
    if (mag >= 16'd1280) begin
      sig_y = 16'd256;
    end else if (mag >= 16'd608) begin
      sig_y = (mag >> 5) + 16'd216;
    end else if (mag >= 16'd256) begin
      sig_y = (mag >> 3) + 16'd160;
    end else begin
      sig_y = (mag >> 2) + 16'd128;
    end
    s2_next = s1_v[15] ? (16'd256 - sig_y) : sig_y;
`ifdef NPU_SIG_LINEAR_BYPASS_EN
    if (s1_bypass) begin
      s2_next = s1_v;
    end
`endif
  end

  // Control path: synchronous active-low reset flushes both stages and the FIFO.
  // NOTE: sequential state uses non-blocking assignments. Every register then
  // samples pre-edge values, whatever order the statements are written in.
  always_ff @(posedge CLK) begin
    if (!npu_rst_n) begin
      credits    <= '0;
      fifo_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;

      if (npu_sig_acc_valid && !npu_sig_acc_ready) begin
        overflow_q <= 1'b1;
      end

      case ({accept, pop})
        2'b10:   credits <= credits + CNT_ONE;
        2'b01:   credits <= credits - CNT_ONE;
        default: ;
      endcase

      // Pointers wrap naturally because FIFO_DEPTH is a power of 2.
      if (s2_valid) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end

      case ({s2_valid, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
        default: ;
      endcase
    end
  end

  // Datapath: qualified by the valids above, so no reset is needed.
  // NOTE: the data registers and FIFO array are deliberately not reset. Stale
  // contents are never observable, because the valid flags, pointers and
  // count are reset and the output data is gated by out_valid.
  always_ff @(posedge CLK) begin
    if (accept) begin
      s1_v <= sat_v;
`ifdef NPU_SIG_LINEAR_BYPASS_EN
      s1_bypass <= npu_sig_bypass;
`endif
    end
    if (s1_valid) begin
      s2_data <= s2_next;
    end
    if (s2_valid) begin
      fifo_mem[wr_ptr] <= s2_data;
    end
  end

endmodule

// File: tb/tb_npu_sigmoid_unit.sv
// -----------------------------------------------------------------------------
// tb_npu_sigmoid_unit
//
// Directed bench for npu_sigmoid_unit in its default configuration. It covers:
//   - the sigmoid transfer function, from a table of hand-computed vectors
//   - latency, credit back-pressure and overflow behaviour
//   - streaming at full throughput
//   - reset in mid-operation
// Inputs are driven 1 ns after the rising edge, and outputs are sampled at the
// same point.
// -----------------------------------------------------------------------------
module tb_npu_sigmoid_unit;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  logic               CLK = 1'b0;
  logic               rst_n;
  logic               acc_valid;
  logic signed [47:0] acc_in;
  logic               acc_ready;
  logic               out_valid;
  logic [15:0]        out_data;
  logic               out_ready;
  logic [CNT_W-1:0]   fifo_count;
  logic               overflow;
`ifdef NPU_SIG_LINEAR_BYPASS_EN
  logic               bypass = 1'b0;
`endif

  npu_sigmoid_unit #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FRAC_BITS  (8)
  ) dut (
    .CLK                (CLK),
    .npu_rst_n          (rst_n),
    .npu_sig_acc_valid  (acc_valid),
    .npu_sig_acc_in     (acc_in),
`ifdef NPU_SIG_LINEAR_BYPASS_EN
    .npu_sig_bypass     (bypass),
`endif
    .npu_sig_acc_ready  (acc_ready),
    .npu_sig_out_valid  (out_valid),
    .npu_sig_out_data   (out_data),
    .npu_sig_out_ready  (out_ready),
    .npu_sig_fifo_count (fifo_count),
    .npu_sig_overflow   (overflow)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [47:0] acc;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] drain_exp[4];

    // Expected values are hand-computed from v = acc >>> 8 (saturated to
    // +/-32767) and the piecewise sigmoid.
    vecs[0]  = '{48'h000000000000, 16'h0080};  // v=0
    vecs[1]  = '{48'h000000010000, 16'h00C0};  // v=256
    vecs[2]  = '{48'hFFFFFFFF0000, 16'h0040};  // v=-256
    vecs[3]  = '{48'h000000030000, 16'h00F0};  // v=768: 24+216
    vecs[4]  = '{48'h7FFFFFFFFFFF, 16'h0100};  // positive saturation
    vecs[5]  = '{48'h800000000000, 16'h0000};  // negative saturation
    vecs[6]  = '{48'h000000006400, 16'h0099};  // v=100: 25+128
    vecs[7]  = '{48'h00000000FF00, 16'h00BF};  // v=255: 63+128
    vecs[8]  = '{48'h000000025F00, 16'h00EB};  // v=607: 75+160
    vecs[9]  = '{48'h000000026000, 16'h00EB};  // v=608: 19+216
    vecs[10] = '{48'h00000004FF00, 16'h00FF};  // v=1279: 39+216
    vecs[11] = '{48'h000000050000, 16'h0100};  // v=1280
    vecs[12] = '{48'hFFFFFFFDA800, 16'h0015};  // v=-600: 256-235
    vecs[13] = '{48'hFFFFFFFFFB00, 16'h007F};  // v=-5: 256-129
    vecs[14] = '{48'hFFFFFF800000, 16'h0000};  // v=-32768 saturates to -32767
    vecs[15] = '{48'h0000000001FF, 16'h0080};  // fraction truncated, v=1

    rst_n     = 1'b0;
    acc_valid = 1'b0;
    acc_in    = '0;
    out_ready = 1'b0;

    // ---- reset state ----
    step();
    step();
    check("rst_acc_ready", acc_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_acc_ready", acc_ready, 1);

    // ---- table: one word at a time, latency and value ----
    for (int i = 0; i < 16; i++) begin
      acc_in    = vecs[i].acc;
      acc_valid = 1'b1;
      check($sformatf("vec%0d_ready", i), acc_ready, 1);
      step();                       // edge N: accept
      acc_valid = 1'b0;
      check($sformatf("vec%0d_valid_n0", i), out_valid, 0);
      step();                       // edge N+1
      check($sformatf("vec%0d_valid_n1", i), out_valid, 0);
      step();                       // edge N+2: FIFO write
      check($sformatf("vec%0d_valid_n2", i), out_valid, 1);
      check($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
      check($sformatf("vec%0d_count", i), fifo_count, 1);
      out_ready = 1'b1;
      step();                       // pop
      out_ready = 1'b0;
      check($sformatf("vec%0d_count_after_pop", i), fifo_count, 0);
    end

    // ---- back-pressure: out_ready low, stream six words ----
    for (int k = 1; k <= 6; k++) begin
      acc_in    = 48'(k) << 16;
      acc_valid = 1'b1;
      check($sformatf("bp_ready_k%0d", k), acc_ready, (k <= 4) ? 1 : 0);
      step();
      check($sformatf("bp_overflow_k%0d", k), overflow, (k >= 5) ? 1 : 0);
    end
    acc_valid = 1'b0;
    check("bp_count_full", fifo_count, 4);
    check("bp_ready_full", acc_ready, 0);
    check("bp_head", out_data, 16'h00C0);
    step();
    step();
    check("bp_head_steady", out_data, 16'h00C0);
    check("bp_count_steady", fifo_count, 4);

    drain_exp[0] = 16'h00C0;  // v=256
    drain_exp[1] = 16'h00E0;  // v=512: 64+160
    drain_exp[2] = 16'h00F0;  // v=768: 24+216
    drain_exp[3] = 16'h00F8;  // v=1024: 32+216
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_valid", i), out_valid, 1);
      check($sformatf("drain%0d_data", i), out_data, drain_exp[i]);
      step();
      if (i == 0) check("drain_credit_ready", acc_ready, 1);
    end
    check("drain_empty_valid", out_valid, 0);
    check("drain_empty_count", fifo_count, 0);
    check("overflow_sticky", overflow, 1);

    // ---- full-throughput stream with out_ready held high ----
    for (int t = 0; t < 19; t++) begin
      if (t < 16) begin
        acc_in    = 48'(t + 1) << 8;   // v = t+1, all in the a<256 segment
        acc_valid = 1'b1;
        check($sformatf("stream_ready_t%0d", t), acc_ready, 1);
      end else begin
        acc_valid = 1'b0;
      end
      if (t >= 3) begin
        check($sformatf("stream_valid_t%0d", t), out_valid, 1);
        check($sformatf("stream_data_w%0d", t - 3), out_data, 16'(((t - 2) >> 2) + 128));
      end else begin
        check($sformatf("stream_valid_t%0d", t), out_valid, 0);
      end
      step();
    end
    acc_valid = 1'b0;
    check("stream_end_valid", out_valid, 0);
    out_ready = 1'b0;
    check("overflow_still_set", overflow, 1);

    // ---- reset with 2 words in FIFO and 1 in stage 2 ----
    for (int j = 0; j < 3; j++) begin
      acc_in    = 48'(j + 1) << 16;
      acc_valid = 1'b1;
      step();
    end
    acc_valid = 1'b0;
    step();
    check("prerst_count", fifo_count, 2);
    rst_n = 1'b0;
    #1;
    check("inrst_acc_ready", acc_ready, 0);
    step();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_out_data", out_data, 0);
    rst_n = 1'b1;
    #1;
    check("midrst_release_ready", acc_ready, 1);
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("no_stale_c%0d", c), out_valid, 0);
    end
    acc_in    = 48'h000000006400;
    acc_valid = 1'b1;
    step();
    acc_valid = 1'b0;
    step();
    step();
    check("postrst_valid", out_valid, 1);
    check("postrst_data", out_data, 16'h0099);
    check("postrst_count", fifo_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
